// File: rtl/alu_div_seq_pkg.sv
// Shared opcodes and divider-sequencer state encodings for alu_div_seq.
// The NEG_* states are only reachable when DIV_SIGNED_EN is defined.
package alu_div_seq_pkg;

  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_NEG = 6'h05;
  localparam logic [5:0] OP_ROL = 6'h0A;

  typedef enum logic [2:0] {
    DIVSEQ_IDLE,
    DIVSEQ_SHIFT,
    DIVSEQ_SUB,
    DIVSEQ_DONE,
    DIVSEQ_NEG_A,
    DIVSEQ_NEG_B,
    DIVSEQ_NEG_Q,
    DIVSEQ_NEG_R
  } divseq_state_t;

endpackage

// File: rtl/alu_div_seq.sv
// Restoring 32-bit divider sequencing the shared ALU (ROL + SUB per bit).
// Define DIV_SIGNED_EN to add req_signed and the NEG_A/NEG_B/NEG_Q/NEG_R fix-up states.
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
`ifdef DIV_SIGNED_EN
  input  logic        req_signed,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_quot,
  output logic [31:0] resp_rem,
  output logic        resp_div0,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_din_a,
  output logic [31:0] alu_din_b,
  output logic        alu_cin,
  output logic [5:0]  alu_opcode,
  output logic        alu_shift_instr,
  input  logic [31:0] alu_dout,
  input  logic        alu_cout
);

  divseq_state_t state, state_next, post_state;
  logic [31:0] r_q, q_q, d_q;
  logic [4:0]  cnt;
  logic        rtop;
  logic        sub_take;
`ifdef DIV_SIGNED_EN
  logic        sgn_a, sgn_b;
`endif

  assign req_ready  = (state == DIVSEQ_IDLE);
  assign resp_valid = (state == DIVSEQ_DONE);

  // rtop set means the 33-bit partial remainder already exceeds D.
  assign sub_take = alu_cout | rtop;

  always_comb begin
`ifdef DIV_SIGNED_EN
    if (sgn_a ^ sgn_b)  post_state = DIVSEQ_NEG_Q;
    else if (sgn_a)     post_state = DIVSEQ_NEG_R;
    else                post_state = DIVSEQ_DONE;
`else
    post_state = DIVSEQ_DONE;
`endif
  end

  always_comb begin
    state_next      = state;
    alu_req         = 1'b0;
    alu_din_a       = '0;
    alu_din_b       = '0;
    alu_cin         = 1'b0;
    alu_opcode      = '0;
    alu_shift_instr = 1'b0;
    case (state)
      DIVSEQ_IDLE: begin
        if (req_valid) begin
          if (req_divisor == '0) state_next = DIVSEQ_DONE;
`ifdef DIV_SIGNED_EN
          else if (req_signed && req_dividend[31]) state_next = DIVSEQ_NEG_A;
          else if (req_signed && req_divisor[31])  state_next = DIVSEQ_NEG_B;
`endif
          else state_next = DIVSEQ_SHIFT;
        end
      end
      DIVSEQ_SHIFT: begin
        alu_req         = 1'b1;
        alu_opcode      = OP_ROL;
        alu_din_a       = r_q;
        alu_din_b       = 32'd1;
        alu_cin         = q_q[31];
        alu_shift_instr = 1'b1;
        if (alu_gnt) state_next = DIVSEQ_SUB;
      end
      DIVSEQ_SUB: begin
        alu_req    = 1'b1;
        alu_opcode = OP_SUB;
        alu_din_a  = r_q;
        alu_din_b  = d_q;
        if (alu_gnt) state_next = (cnt == '0) ? post_state : DIVSEQ_SHIFT;
      end
      DIVSEQ_DONE: begin
        if (resp_ready) state_next = DIVSEQ_IDLE;
      end
`ifdef DIV_SIGNED_EN
      DIVSEQ_NEG_A: begin
        alu_req    = 1'b1;
        alu_opcode = OP_NEG;
        alu_din_b  = q_q;
        if (alu_gnt) state_next = sgn_b ? DIVSEQ_NEG_B : DIVSEQ_SHIFT;
      end
      DIVSEQ_NEG_B: begin
        alu_req    = 1'b1;
        alu_opcode = OP_NEG;
        alu_din_b  = d_q;
        if (alu_gnt) state_next = DIVSEQ_SHIFT;
      end
      DIVSEQ_NEG_Q: begin
        alu_req    = 1'b1;
        alu_opcode = OP_NEG;
        alu_din_b  = resp_quot;
        if (alu_gnt) state_next = sgn_a ? DIVSEQ_NEG_R : DIVSEQ_DONE;
      end
      DIVSEQ_NEG_R: begin
        alu_req    = 1'b1;
        alu_opcode = OP_NEG;
        alu_din_b  = resp_rem;
        if (alu_gnt) state_next = DIVSEQ_DONE;
      end
`endif
      default: state_next = DIVSEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= DIVSEQ_IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt       <= '0;
      rtop      <= 1'b0;
      resp_quot <= '0;
      resp_rem  <= '0;
      resp_div0 <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_a     <= 1'b0;
      sgn_b     <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        DIVSEQ_IDLE: begin
          if (req_valid) begin
            d_q <= req_divisor;
            q_q <= req_dividend;
            r_q <= '0;
            cnt <= 5'd31;
`ifdef DIV_SIGNED_EN
            sgn_a <= req_signed & req_dividend[31];
            sgn_b <= req_signed & req_divisor[31];
`endif
            if (req_divisor == '0) begin
              resp_quot <= DIV0_QUOT;
              resp_rem  <= req_dividend;
              resp_div0 <= 1'b1;
            end else begin
              resp_div0 <= 1'b0;
            end
          end
        end
        DIVSEQ_SHIFT: begin
          if (alu_gnt) begin
            r_q  <= alu_dout;
            rtop <= alu_cout;
            q_q  <= {q_q[30:0], 1'b0};
          end
        end
        DIVSEQ_SUB: begin
          if (alu_gnt) begin
            if (sub_take) begin
              r_q    <= alu_dout;
              q_q[0] <= 1'b1;
            end
            // Results are captured from the in-flight step since Q/R update on this same edge.
            if (cnt == '0) begin
              resp_quot <= {q_q[31:1], sub_take};
              resp_rem  <= sub_take ? alu_dout : r_q;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
        end
`ifdef DIV_SIGNED_EN
        DIVSEQ_NEG_A: if (alu_gnt) q_q       <= alu_dout;
        DIVSEQ_NEG_B: if (alu_gnt) d_q       <= alu_dout;
        DIVSEQ_NEG_Q: if (alu_gnt) resp_quot <= alu_dout;
        DIVSEQ_NEG_R: if (alu_gnt) resp_rem  <= alu_dout;
`endif
        default: ;
      endcase
    end
  end

endmodule
